// File: rtl/seq_alu.sv
// seq_alu: registered, parametrised ALU with a start/busy/done handshake.
//
// Single-cycle ops (CLR/ADD/SUB/AND/PASS/SHL/CMP) are accepted from IDLE and
// complete on the accept edge. MUL runs a WIDTH-step shift-add on the latched
// operands and writes {Hi,Low} on completion.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   Start       request, accepted when Busy=0
//   Op[2:0]     operation select (sampled on accept)
//   A, B        operands (sampled on accept)
//   Result      registered result
//   Hi, Low     upper/lower half of the last product
//   Status      registered flags {Z,N,C,V}
//   Busy        multiply in progress
//   Done        one-cycle completion pulse
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Low,
  output logic [3:0]       Status,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [2:0] {
    OP_CLR  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_PASS = 3'b100,
    OP_SHL  = 3'b101,
    OP_MUL  = 3'b110,
    OP_CMP  = 3'b111
  } op_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [3:0]           status_q, status_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  // multiply datapath: multiplicand shifts left, multiplier shifts right
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [SHW-1:0]       cnt_q, cnt_d;

  // single-cycle arithmetic on the live operands (they are the accepted ones)
  logic [WIDTH:0]       sum, diff;
  logic [WIDTH-1:0]     shl;
  logic                 add_v, sub_v;
  logic [2*WIDTH-1:0]   acc_step;

  always_comb begin
    sum   = {1'b0, A} + {1'b0, B};
    diff  = {1'b0, A} - {1'b0, B};
    // any bit of B at or above SHW means the shift clears everything
    shl   = (|B[WIDTH-1:SHW]) ? '0 : (A << B[SHW-1:0]);
    add_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    sub_v = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
    acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    status_d = status_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          done_d = 1'b1;
          case (op_e'(Op))
            OP_CLR: begin
              result_d = '0;
              status_d = 4'b1000;
            end
            OP_ADD: begin
              result_d = sum[WIDTH-1:0];
              status_d = {sum[WIDTH-1:0] == '0, sum[WIDTH-1], sum[WIDTH], add_v};
            end
            OP_SUB: begin
              result_d = diff[WIDTH-1:0];
              status_d = {diff[WIDTH-1:0] == '0, diff[WIDTH-1], diff[WIDTH], sub_v};
            end
            OP_AND: begin
              result_d = A & B;
              status_d = {(A & B) == '0, A[WIDTH-1] & B[WIDTH-1], 2'b00};
            end
            OP_PASS: begin
              result_d = B;
              status_d = {B == '0, B[WIDTH-1], 2'b00};
            end
            OP_SHL: begin
              result_d = shl;
              status_d = {shl == '0, shl[WIDTH-1], 2'b00};
            end
            OP_CMP: begin
              // flags only; Result keeps its value
              status_d = {diff[WIDTH-1:0] == '0, diff[WIDTH-1], diff[WIDTH], sub_v};
            end
            OP_MUL: begin
              done_d  = 1'b0;
              state_d = S_MUL;
              busy_d  = 1'b1;
              mcand_d = {{WIDTH{1'b0}}, A};
              mplr_d  = B;
              acc_d   = '0;
              cnt_d   = '0;
            end
            default: done_d = 1'b0;
          endcase
        end
      end

      S_MUL: begin
        acc_d   = acc_step;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + SHW'(1);
        // last step: publish the product directly from the adder output
        if (cnt_q == CNT_LAST) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          hi_d     = acc_step[2*WIDTH-1:WIDTH];
          lo_d     = acc_step[WIDTH-1:0];
          result_d = acc_step[WIDTH-1:0];
          status_d = {acc_step == '0, 1'b0, 1'b0, acc_step[2*WIDTH-1:WIDTH] != '0};
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      status_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      status_q <= status_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Result = result_q;
  assign Hi     = hi_q;
  assign Low    = lo_q;
  assign Status = status_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16): reset, single-cycle ops back to back,
// multi-cycle MUL with ignored mid-busy Start, busy-fall boundary, and abort.
module tb_seq_alu;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         Start;
  logic [2:0]   Op;
  logic [W-1:0] A, B;
  logic [W-1:0] Result, Hi, Low;
  logic [3:0]   Status;
  logic         Busy, Done;

  int total = 0;
  int bad   = 0;
  int busy_cycles;
  int done_seen;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Result(Result), .Hi(Hi), .Low(Low), .Status(Status),
    .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    Start = s; Op = op; A = a; B = b;
  endtask

  initial begin
    // reset held two edges with a live ADD request
    rst = 1'b1;
    drive(1'b1, 3'b001, 16'h0001, 16'h0001);
    tick(); tick();
    chk("rst_result", 32'(Result), 'h0);
    chk("rst_hi",     32'(Hi),     'h0);
    chk("rst_low",    32'(Low),    'h0);
    chk("rst_status", 32'(Status), 'h0);
    chk("rst_busy",   32'(Busy),   'h0);
    chk("rst_done",   32'(Done),   'h0);

    rst = 1'b0;
    drive(1'b1, 3'b001, 16'h7FFF, 16'h0001);
    tick();
    chk("add_ovf_res",  32'(Result), 'h8000);
    chk("add_ovf_stat", 32'(Status), 'h5);
    chk("add_ovf_done", 32'(Done),   'h1);
    drive(1'b0, 3'b001, 16'h0, 16'h0);
    tick();
    chk("done_pulse_end", 32'(Done), 'h0);

    // back-to-back single-cycle ops
    drive(1'b1, 3'b001, 16'hFFFF, 16'h0001);
    tick();
    chk("add_carry_res",  32'(Result), 'h0000);
    chk("add_carry_stat", 32'(Status), 'hA);
    drive(1'b1, 3'b010, 16'h0003, 16'h0005);
    tick();
    chk("sub_res",  32'(Result), 'hFFFE);
    chk("sub_stat", 32'(Status), 'h6);
    chk("sub_done", 32'(Done),   'h1);
    drive(1'b1, 3'b111, 16'h1234, 16'h1234);
    tick();
    chk("cmp_res",  32'(Result), 'hFFFE);
    chk("cmp_stat", 32'(Status), 'h8);
    chk("cmp_done", 32'(Done),   'h1);
    drive(1'b1, 3'b101, 16'h0001, 16'd15);
    tick();
    chk("shl15_res",  32'(Result), 'h8000);
    chk("shl15_stat", 32'(Status), 'h4);
    drive(1'b1, 3'b101, 16'h0001, 16'd16);
    tick();
    chk("shl16_res",  32'(Result), 'h0000);
    chk("shl16_stat", 32'(Status), 'h8);
    drive(1'b1, 3'b100, 16'h1111, 16'hA5A5);
    tick();
    chk("pass_res",  32'(Result), 'hA5A5);
    chk("pass_stat", 32'(Status), 'h4);
    drive(1'b1, 3'b011, 16'hF0F0, 16'hFF00);
    tick();
    chk("and_res",  32'(Result), 'hF000);
    chk("and_stat", 32'(Status), 'h4);
    drive(1'b1, 3'b000, 16'h1234, 16'h5678);
    tick();
    chk("clr_res",  32'(Result), 'h0000);
    chk("clr_stat", 32'(Status), 'h8);

    // MUL 0xFFFF * 0xFFFF with an ignored CLR request mid-busy
    drive(1'b1, 3'b110, 16'hFFFF, 16'hFFFF);
    tick();
    drive(1'b0, 3'b000, 16'h0, 16'h0);
    chk("mul_busy_on", 32'(Busy), 'h1);
    busy_cycles = 0;
    for (int i = 0; i < 40 && Busy; i++) begin
      busy_cycles++;
      if (i == 3) Start = 1'b1;
      if (i == 5) Start = 1'b0;
      if (i == 8) begin
        chk("mul_hi_hold",  32'(Low),  'h0000);
        chk("mul_mid_done", 32'(Done), 'h0);
      end
      tick();
    end
    chk("mul_busy_cycles", 32'(busy_cycles), 'd16);
    chk("mul_done", 32'(Done),   'h1);
    chk("mul_hi",   32'(Hi),     'hFFFE);
    chk("mul_low",  32'(Low),    'h0001);
    chk("mul_res",  32'(Result), 'h0001);
    chk("mul_stat", 32'(Status), 'h1);
    tick();
    chk("mul_done_end", 32'(Done),   'h0);
    chk("mul_ign_res",  32'(Result), 'h0001);

    // Start held through the busy-fall edge: accepted one edge later
    drive(1'b1, 3'b110, 16'h0003, 16'h0005);
    tick();
    drive(1'b1, 3'b001, 16'h0002, 16'h0002);
    for (int i = 0; i < 40 && Busy; i++) tick();
    chk("mul2_done", 32'(Done),   'h1);
    chk("mul2_res",  32'(Result), 'h000F);
    chk("mul2_hi",   32'(Hi),     'h0000);
    chk("mul2_stat", 32'(Status), 'h0);
    tick();
    chk("fall_add_res",  32'(Result), 'h0004);
    chk("fall_add_done", 32'(Done),   'h1);
    chk("fall_add_low",  32'(Low),    'h000F);
    drive(1'b0, 3'b000, 16'h0, 16'h0);

    // abort a MUL at iteration 8
    drive(1'b1, 3'b110, 16'h0100, 16'h0100);
    tick();
    drive(1'b0, 3'b000, 16'h0, 16'h0);
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(Busy), 'h0);
    chk("abort_hi",   32'(Hi),   'h0);
    chk("abort_low",  32'(Low),  'h0);
    chk("abort_done", 32'(Done), 'h0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Done) done_seen++;
    end
    chk("abort_no_late_done", 32'(done_seen), 'd0);
    drive(1'b1, 3'b001, 16'h0001, 16'h0002);
    tick();
    drive(1'b0, 3'b000, 16'h0, 16'h0);
    chk("post_abort_res",  32'(Result), 'h0003);
    chk("post_abort_done", 32'(Done),   'h1);
    chk("post_abort_stat", 32'(Status), 'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the datapath's combinational 16-bit ALU.
- Keeps the same 3-bit op encoding and the Z/N/C/V flag positions.
- Adds a start/busy/done handshake, latches operands on accept, and registers all results and flags.
- Multiplication is a multi-cycle shift-add unit writing Hi/Low, so the control unit can sequence it.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4).
- SHW, $clog2(WIDTH), width of the shift amount taken from B (derived; do not override).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- Start  in  1  request; accepted only on an edge where Start=1 and Busy=0.
- Op  in  3  operation select, sampled on accept.
- A  in  WIDTH  operand A, sampled on accept.
- B  in  WIDTH  operand B, sampled on accept.
- Result  out  WIDTH  registered result.
- Hi  out  WIDTH  upper half of the last product.
- Low  out  WIDTH  lower half of the last product.
- Status  out  4  registered flags {Z,N,C,V}; bit3=Z, bit2=N, bit1=C, bit0=V.
- Busy  out  1  multiply in progress; new Start is ignored.
- Done  out  1  one-cycle pulse; Result/Status (and Hi/Low for MUL) are valid.

Behaviour:
- Reset:
  - When rst=1 at an edge: Result, Hi, Low, Status, Busy and Done all go to 0, and the FSM goes to IDLE.
  - rst has priority over Start.
  - rst during MUL aborts the multiply; no Done is produced and Hi/Low are cleared.
- FSM states:
  - IDLE: accepts Start. Single-cycle ops stay in IDLE; Op=110 goes to MUL.
  - MUL: runs WIDTH iterations, then returns to IDLE.
- Single-cycle latency:
  - Accept at edge k.
  - At edge k, Result and Status are updated and Done=1 for exactly the cycle after edge k.
  - Back-to-back Starts every cycle are legal and give one Done per op.
- Op encoding and Result:
  - 000 CLR: Result=0.
  - 001 ADD: Result=A+B mod 2^WIDTH.
  - 010 SUB: Result=A-B mod 2^WIDTH.
  - 011 AND: Result=A&B.
  - 100 PASS: Result=B.
  - 101 SHL: Result=A<<B[SHW-1:0]. If B>=WIDTH (any upper bit set), Result=0.
  - 110 MUL: unsigned; {Hi,Low}=A*B; Result=Low.
  - 111 CMP: flags as SUB; Result and Hi/Low unchanged.
- Flags (Status always written on every Done):
  - Z: the written value is all zero. This is the Result for ops 000–101, the full 2*WIDTH product for MUL, and A-B for CMP.
  - N: bit WIDTH-1 of that value; for MUL, N=0.
  - C:
    - ADD: carry-out of the WIDTH+1-bit sum.
    - SUB/CMP: borrow, i.e. 1 iff A<B unsigned.
    - All other ops: 0.
  - V:
    - ADD: A and B have the same sign and the result sign differs.
    - SUB/CMP: A and B have different signs and the result sign differs from A.
    - MUL: 1 iff Hi!=0.
    - All other ops: 0.
- MUL sequencing:
  - Accept at edge k: Busy=1 after edge k, and the accumulator and counter are cleared.
  - Edges k+1..k+WIDTH each perform one shift-add step on the latched operands.
  - At edge k+WIDTH: Hi, Low, Result and Status are written, Busy=0 and Done=1.
  - Total latency is WIDTH+1 edges from accept to the end of the Done cycle.
  - Hi/Low are not updated mid-iteration; they hold the previous product until completion.
- Hold rules:
  - Start while Busy=1 is ignored; no queuing.
  - Operands or Op changing after accept have no effect.
  - Hi/Low change only on MUL completion or reset.
  - Result changes only on a Done edge of a non-CMP op.
  - Start at the same edge Busy falls is not accepted; it is accepted on the next edge if still held.

Test Plan:
- Reset: drive rst=1 for 2 cycles with Start=1, Op=001 -> all outputs 0, no Done; release rst -> the next accept works.
- ADD, WIDTH=16:
  - A=0x7FFF, B=0x0001 -> Result=0x8000, Status=0b0101 (N,V), Done one cycle.
  - A=0xFFFF, B=0x0001 -> Result=0x0000, Status=0b1010 (Z,C).
- SUB/CMP:
  - SUB A=0x0003, B=0x0005 -> Result=0xFFFE, Status=0b0110 (N,C).
  - CMP A=0x1234, B=0x1234 after that SUB -> Status=0b1000 and Result stays 0xFFFE.
- SHL and PASS:
  - A=0x0001, B=15 -> Result=0x8000, N=1.
  - B=16 -> Result=0x0000, Z=1.
  - PASS B=0xA5A5 -> Result=0xA5A5.
- MUL:
  - A=0xFFFF, B=0xFFFF -> Busy high for exactly 16 cycles; Done at edge k+16 with Hi=0xFFFE, Low=0x0001, Result=0x0001, V=1.
  - Start pulsed mid-busy with Op=000 is ignored and Result is unchanged.
- Abort: assert rst at iteration 8 of a MUL (A=0x0100, B=0x0100) -> Busy=0, Hi=Low=0, no Done; a following ADD completes normally in 1 cycle.
